apb_event_unit_mc: RTL and testbench

- Parametrised multi-channel successor to the APB interrupt/event/sleep unit. It combines in one block:
  - NUM_LINES request lines, each with a per-line edge/level mode;
  - a fixed-priority encoder that presents one request and its ID to the core, with an ID-qualified acknowledge;
  - a sleep controller with a programmable wake-up delay.
- Sits on the peripheral APB bus next to the core. Drives the core's interrupt request, clock gate and fetch enable.

---
 rtl/apb_event_unit_mc_pkg.sv | 33 +++
 rtl/event_prio_enc.sv | 30 +++
 rtl/apb_event_unit_mc.sv | 211 +++++++++++++++++++++
 tb/tb_apb_event_unit_mc.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_event_unit_mc_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// apb_event_unit_mc_pkg
// Shared definitions for the multi-channel APB event unit.
//   - REG_* : register indices, selected by PADDR[4:2]
//   - sleep_state_t : sleep controller state encoding (readable via SLEEP)
//   - status_t : layout of the STATUS register (request flag in bit 31,
//                zero-extended request ID in the low bits)
// ---------------------------------------------------------------------------
package apb_event_unit_mc_pkg;

    localparam logic [2:0] REG_ENABLE   = 3'd0;
    localparam logic [2:0] REG_PENDING  = 3'd1;
    localparam logic [2:0] REG_SET      = 3'd2;
    localparam logic [2:0] REG_CLEAR    = 3'd3;
    localparam logic [2:0] REG_MODE     = 3'd4;
    localparam logic [2:0] REG_WAKEMASK = 3'd5;
    localparam logic [2:0] REG_SLEEP    = 3'd6;
    localparam logic [2:0] REG_STATUS   = 3'd7;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SLEEP_REQ = 2'd1,
        SLEEP     = 2'd2,
        WAKE      = 2'd3
    } sleep_state_t;

    typedef struct packed {
        logic        req;
        logic [30:0] id;
    } status_t;

endpackage

// File: rtl/event_prio_enc.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// event_prio_enc
// Combinational fixed-priority encoder: the lowest set index wins.
// Ports:
//   req   [WIDTH-1:0]     request vector
//   valid                 at least one request bit is set
//   id    [ID_WIDTH-1:0]  index of the lowest set bit (0 when none)
// ---------------------------------------------------------------------------
module event_prio_enc #(
    parameter int WIDTH    = 32,
    parameter int ID_WIDTH = 5
) (
    input  logic [WIDTH-1:0]    req,
    output logic                valid,
    output logic [ID_WIDTH-1:0] id
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/apb_event_unit_mc.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// apb_event_unit_mc
// APB-mapped multi-channel event/interrupt unit with a sleep controller.
// Ports:
//   HCLK, HRESET            clock, synchronous active-high reset
//   PADDR/PWDATA/PWRITE/
//   PSEL/PENABLE            APB request; PADDR[4:2] selects the register
//   PRDATA/PREADY/PSLVERR   APB response (combinational, zero wait state)
//   line_i                  request lines (edge or level per MODE bit)
//   irq_req_o/irq_id_o      registered request and ID presented to the core
//   irq_ack_i/irq_ack_id_i  ID-qualified acknowledge from the core
//   core_busy_i             core still has activity in flight
//   fetch_en_o              core fetch enable
//   clk_gate_core_o         core clock enable (1 = running)
// ---------------------------------------------------------------------------
module apb_event_unit_mc
    import apb_event_unit_mc_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_LINES      = 32,
    parameter int ID_WIDTH       = 5,
    parameter int WAKE_CYCLES    = 4
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_LINES-1:0]      line_i,
    output logic                      irq_req_o,
    output logic [ID_WIDTH-1:0]       irq_id_o,
    input  logic                      irq_ack_i,
    input  logic [ID_WIDTH-1:0]       irq_ack_id_i,
    input  logic                      core_busy_i,
    output logic                      fetch_en_o,
    output logic                      clk_gate_core_o
);

    logic [NUM_LINES-1:0] enable_q, pending_q, mode_q, wakemask_q, line_q;
    logic [NUM_LINES-1:0] pending_d, ack_vec, sw_set, sw_clr, edge_set, active;
    logic [NUM_LINES-1:0] wdata;
    sleep_state_t         state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 irq_req_q, enc_valid;
    logic [ID_WIDTH-1:0]  irq_id_q, enc_id;
    logic                 fetch_en_q, fetch_en_d, clk_gate_q, clk_gate_d;
    logic                 apb_access, addr_err, status_wr, wr_en, sleep_wr, wake;
    logic [2:0]           reg_sel;
    status_t              status;
    logic                 unused_addr_lsbs;

    assign unused_addr_lsbs = ^PADDR[1:0];

    // APB decode: out-of-range addresses and STATUS writes are rejected
    // with PSLVERR and must not touch any state.
    assign reg_sel    = PADDR[4:2];
    assign apb_access = PSEL & PENABLE;
    assign addr_err   = |PADDR[APB_ADDR_WIDTH-1:5];
    assign status_wr  = PWRITE && (reg_sel == REG_STATUS);
    assign PSLVERR    = apb_access & (addr_err | status_wr);
    assign wr_en      = apb_access & PWRITE & ~addr_err & ~status_wr;
    assign sleep_wr   = wr_en && (reg_sel == REG_SLEEP) && PWDATA[0];
    assign PREADY     = 1'b1;
    assign wdata      = PWDATA[NUM_LINES-1:0];

    assign status.req = irq_req_q;
    assign status.id  = 31'(irq_id_q);

    // Read mux; bits above NUM_LINES stay zero from the default.
    always_comb begin
        PRDATA = '0;
        if (PSEL && !addr_err) begin
            case (reg_sel)
                REG_ENABLE:   PRDATA[NUM_LINES-1:0] = enable_q;
                REG_PENDING:  PRDATA[NUM_LINES-1:0] = pending_q;
                REG_MODE:     PRDATA[NUM_LINES-1:0] = mode_q;
                REG_WAKEMASK: PRDATA[NUM_LINES-1:0] = wakemask_q;
                REG_SLEEP:    PRDATA = {30'b0, state_q};
                REG_STATUS:   PRDATA = status;
                default:      PRDATA = '0;
            endcase
        end
    end

    // Pending next-state. Edge bits: hardware edge beats software set, which
    // beats clear/ack, so an edge arriving with its own ack is not lost.
    // Level bits simply follow the line.
    always_comb begin
        ack_vec  = '0;
        sw_set   = '0;
        sw_clr   = '0;
        edge_set = line_i & ~line_q;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (irq_ack_i && (irq_ack_id_i == ID_WIDTH'(i))) begin
                ack_vec[i] = 1'b1;
            end
        end
        if (wr_en) begin
            case (reg_sel)
                REG_SET:     sw_set = wdata;
                REG_CLEAR:   sw_clr = wdata;
                REG_PENDING: begin
                    sw_set = wdata;
                    sw_clr = ~wdata;
                end
                default:     sw_set = '0;
            endcase
        end
        pending_d = (mode_q & (edge_set | sw_set | (pending_q & ~(sw_clr | ack_vec))))
                  | (~mode_q & line_i);
    end

    assign active = pending_q & enable_q;

    event_prio_enc #(
        .WIDTH    (NUM_LINES),
        .ID_WIDTH (ID_WIDTH)
    ) u_prio_enc (
        .req   (active),
        .valid (enc_valid),
        .id    (enc_id)
    );

    // Configuration/pending registers and the registered encoder output.
    // The ID is only refreshed while a request is valid so it holds its
    // last value once the request drops.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            enable_q   <= '0;
            pending_q  <= '0;
            mode_q     <= '1;
            wakemask_q <= '0;
            line_q     <= '0;
            irq_req_q  <= 1'b0;
            irq_id_q   <= '0;
        end else begin
            line_q    <= line_i;
            pending_q <= pending_d;
            irq_req_q <= enc_valid;
            if (enc_valid) begin
                irq_id_q <= enc_id;
            end
            if (wr_en) begin
                case (reg_sel)
                    REG_ENABLE:   enable_q   <= wdata;
                    REG_MODE:     mode_q     <= wdata;
                    REG_WAKEMASK: wakemask_q <= wdata;
                    default:      ;
                endcase
            end
        end
    end

    assign wake = |(pending_q & (enable_q | wakemask_q));

    // Sleep controller next-state; outputs are derived from the next state
    // so they change on the same edge as the state itself.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (sleep_wr) state_d = SLEEP_REQ;
            end
            SLEEP_REQ: begin
                if (wake)              state_d = RUN;
                else if (!core_busy_i) state_d = SLEEP;
            end
            SLEEP: begin
                if (wake) begin
                    state_d = WAKE;
                    cnt_d   = 8'(WAKE_CYCLES - 1);
                end
            end
            WAKE: begin
                if (cnt_q == 8'd0) state_d = RUN;
                else               cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = RUN;
        endcase
        fetch_en_d = (state_d == RUN) || (state_d == SLEEP_REQ);
        clk_gate_d = (state_d != SLEEP);
    end

    // Sleep controller state, wake counter and registered core controls.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            fetch_en_q <= 1'b1;
            clk_gate_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fetch_en_q <= fetch_en_d;
            clk_gate_q <= clk_gate_d;
        end
    end

    assign irq_req_o       = irq_req_q;
    assign irq_id_o        = irq_id_q;
    assign fetch_en_o      = fetch_en_q;
    assign clk_gate_core_o = clk_gate_q;

endmodule

// File: tb/tb_apb_event_unit_mc.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_apb_event_unit_mc
// Directed bench for apb_event_unit_mc with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_apb_event_unit_mc;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] line_i;
    logic        irq_req_o;
    logic [4:0]  irq_id_o;
    logic        irq_ack_i;
    logic [4:0]  irq_ack_id_i;
    logic        core_busy_i;
    logic        fetch_en_o, clk_gate_core_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd;
    logic        err;

    apb_event_unit_mc #(
        .APB_ADDR_WIDTH (12),
        .NUM_LINES      (32),
        .ID_WIDTH       (5),
        .WAKE_CYCLES    (4)
    ) dut (
        .HCLK            (HCLK),
        .HRESET          (HRESET),
        .PADDR           (PADDR),
        .PWDATA          (PWDATA),
        .PWRITE          (PWRITE),
        .PSEL            (PSEL),
        .PENABLE         (PENABLE),
        .PRDATA          (PRDATA),
        .PREADY          (PREADY),
        .PSLVERR         (PSLVERR),
        .line_i          (line_i),
        .irq_req_o       (irq_req_o),
        .irq_id_o        (irq_id_o),
        .irq_ack_i       (irq_ack_i),
        .irq_ack_id_i    (irq_ack_id_i),
        .core_busy_i     (core_busy_i),
        .fetch_en_o      (fetch_en_o),
        .clk_gate_core_o (clk_gate_core_o)
    );

    always #5 HCLK = ~HCLK;

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected sequence completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive lines and acknowledge for one cycle, ending on the next falling edge.
    task automatic applyStimulus(input logic [31:0] lines, input logic ack, input logic [4:0] ack_id);
        line_i       = lines;
        irq_ack_i    = ack;
        irq_ack_id_i = ack_id;
        @(negedge HCLK);
    endtask

    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data, output logic slverr);
        PADDR   = addr;
        PWDATA  = data;
        PWRITE  = 1'b1;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #1 slverr = PSLVERR;
        @(negedge HCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] addr, output logic [31:0] data, output logic slverr);
        PADDR   = addr;
        PWRITE  = 1'b0;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #1;
        data    = PRDATA;
        slverr  = PSLVERR;
        @(negedge HCLK);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    initial begin
        HRESET       = 1'b1;
        PADDR        = '0;
        PWDATA       = '0;
        PWRITE       = 1'b0;
        PSEL         = 1'b0;
        PENABLE      = 1'b0;
        line_i       = '0;
        irq_ack_i    = 1'b0;
        irq_ack_id_i = '0;
        core_busy_i  = 1'b0;
        repeat (3) @(negedge HCLK);
        checkOutput("rst_fetch_en", 32'(fetch_en_o), 32'd1);
        checkOutput("rst_clk_gate", 32'(clk_gate_core_o), 32'd1);
        checkOutput("rst_irq_req", 32'(irq_req_o), 32'd0);
        checkOutput("rst_pslverr", 32'(PSLVERR), 32'd0);
        HRESET = 1'b0;
        @(negedge HCLK);

        // Reset values of every register
        apb_read(12'h000, rd, err); checkOutput("rst_enable", rd, 32'h0);
        apb_read(12'h004, rd, err); checkOutput("rst_pending", rd, 32'h0);
        apb_read(12'h008, rd, err); checkOutput("rst_set", rd, 32'h0);
        apb_read(12'h00C, rd, err); checkOutput("rst_clear", rd, 32'h0);
        apb_read(12'h010, rd, err); checkOutput("rst_mode", rd, 32'hFFFF_FFFF);
        apb_read(12'h014, rd, err); checkOutput("rst_wakemask", rd, 32'h0);
        apb_read(12'h018, rd, err); checkOutput("rst_sleep", rd, 32'h0);
        apb_read(12'h01C, rd, err); checkOutput("rst_status", rd, 32'h0);

        // Two simultaneous edges, lowest index first, ID-qualified acks
        apb_write(12'h000, 32'h0000_0030, err);
        applyStimulus(32'h30, 1'b0, 5'd0);
        checkOutput("edge_lat_c1", 32'(irq_req_o), 32'd0);
        applyStimulus(32'h0, 1'b0, 5'd0);
        checkOutput("edge_req_c2", 32'(irq_req_o), 32'd1);
        checkOutput("edge_id_c2", 32'(irq_id_o), 32'd4);
        applyStimulus(32'h0, 1'b1, 5'd4);
        checkOutput("ack4_id_k1", 32'(irq_id_o), 32'd4);
        applyStimulus(32'h0, 1'b0, 5'd0);
        checkOutput("ack4_req_k2", 32'(irq_req_o), 32'd1);
        checkOutput("ack4_id_k2", 32'(irq_id_o), 32'd5);
        applyStimulus(32'h0, 1'b1, 5'd5);
        applyStimulus(32'h0, 1'b0, 5'd0);
        checkOutput("ack5_req", 32'(irq_req_o), 32'd0);
        checkOutput("ack5_id_hold", 32'(irq_id_o), 32'd5);

        // Level mode on line 3
        apb_write(12'h010, 32'hFFFF_FFF7, err);
        apb_write(12'h000, 32'h0000_0038, err);
        applyStimulus(32'h8, 1'b0, 5'd0);
        applyStimulus(32'h8, 1'b0, 5'd0);
        checkOutput("lvl_req", 32'(irq_req_o), 32'd1);
        checkOutput("lvl_id", 32'(irq_id_o), 32'd3);
        apb_write(12'h00C, 32'h0000_0008, err);
        checkOutput("lvl_clear_req", 32'(irq_req_o), 32'd1);
        apb_read(12'h004, rd, err); checkOutput("lvl_pending", rd, 32'h8);
        applyStimulus(32'h0, 1'b0, 5'd0);
        checkOutput("lvl_drop_c1", 32'(irq_req_o), 32'd1);
        applyStimulus(32'h0, 1'b0, 5'd0);
        checkOutput("lvl_drop_c2", 32'(irq_req_o), 32'd0);

        // Edge coinciding with its acknowledge stays pending
        applyStimulus(32'h4, 1'b0, 5'd0);
        applyStimulus(32'h0, 1'b0, 5'd0);
        applyStimulus(32'h4, 1'b1, 5'd2);
        applyStimulus(32'h0, 1'b0, 5'd0);
        apb_read(12'h004, rd, err); checkOutput("edge_vs_ack", rd, 32'h4);
        apb_write(12'h00C, 32'h0000_0004, err);
        apb_read(12'h004, rd, err); checkOutput("clear_w1c", rd, 32'h0);
        apb_write(12'h008, 32'h0000_000C, err);
        apb_read(12'h004, rd, err); checkOutput("set_w1s_lvl_ign", rd, 32'h4);
        apb_read(12'h008, rd, err); checkOutput("set_reads0", rd, 32'h0);
        apb_write(12'h004, 32'h0000_0001, err);
        apb_read(12'h004, rd, err); checkOutput("pending_wr", rd, 32'h1);
        apb_write(12'h00C, 32'hFFFF_FFFF, err);

        // Sleep entry held off by busy, wake through WAKEMASK
        apb_write(12'h014, 32'h0000_0080, err);
        core_busy_i = 1'b1;
        apb_write(12'h018, 32'h0000_0001, err);
        repeat (5) applyStimulus(32'h0, 1'b0, 5'd0);
        checkOutput("busy_fetch_en", 32'(fetch_en_o), 32'd1);
        checkOutput("busy_clk_gate", 32'(clk_gate_core_o), 32'd1);
        apb_read(12'h018, rd, err); checkOutput("busy_state", rd, 32'd1);
        core_busy_i = 1'b0;
        applyStimulus(32'h0, 1'b0, 5'd0);
        checkOutput("sleep_clk_gate", 32'(clk_gate_core_o), 32'd0);
        checkOutput("sleep_fetch_en", 32'(fetch_en_o), 32'd0);
        apb_read(12'h018, rd, err); checkOutput("sleep_state", rd, 32'd2);
        applyStimulus(32'h80, 1'b0, 5'd0);
        checkOutput("wake_c1_gate", 32'(clk_gate_core_o), 32'd0);
        applyStimulus(32'h0, 1'b0, 5'd0);
        checkOutput("wake_c2_gate", 32'(clk_gate_core_o), 32'd1);
        checkOutput("wake_c2_fetch", 32'(fetch_en_o), 32'd0);
        repeat (3) applyStimulus(32'h0, 1'b0, 5'd0);
        checkOutput("wake_c5_fetch", 32'(fetch_en_o), 32'd0);
        applyStimulus(32'h0, 1'b0, 5'd0);
        checkOutput("wake_c6_fetch", 32'(fetch_en_o), 32'd1);
        checkOutput("wake_no_irq", 32'(irq_req_o), 32'd0);

        // Error responses leave state untouched
        apb_read(12'h040, rd, err);
        checkOutput("oob_rd_err", 32'(err), 32'd1);
        checkOutput("oob_rd_data", rd, 32'h0);
        apb_write(12'h040, 32'hFFFF_FFFF, err);
        checkOutput("oob_wr_err", 32'(err), 32'd1);
        apb_read(12'h000, rd, err); checkOutput("oob_wr_enable", rd, 32'h38);
        apb_write(12'h01C, 32'hFFFF_FFFF, err);
        checkOutput("status_wr_err", 32'(err), 32'd1);
        apb_read(12'h01C, rd, err);
        checkOutput("status_rd", rd, 32'h3);
        checkOutput("status_rd_err", 32'(err), 32'd0);
        apb_read(12'h004, rd, err); checkOutput("status_wr_pend", rd, 32'h80);

        // Reset while sleeping
        apb_write(12'h00C, 32'hFFFF_FFFF, err);
        apb_write(12'h018, 32'h0000_0001, err);
        applyStimulus(32'h0, 1'b0, 5'd0);
        checkOutput("pre_rst_gate", 32'(clk_gate_core_o), 32'd0);
        HRESET = 1'b1;
        @(negedge HCLK);
        checkOutput("mid_rst_fetch", 32'(fetch_en_o), 32'd1);
        checkOutput("mid_rst_gate", 32'(clk_gate_core_o), 32'd1);
        HRESET = 1'b0;
        @(negedge HCLK);
        apb_read(12'h018, rd, err); checkOutput("mid_rst_state", rd, 32'd0);
        apb_read(12'h010, rd, err); checkOutput("mid_rst_mode", rd, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
